// File: rtl/layer_out_sequencer.sv
// Collects NN parallel neuron results of one layer and streams them out serially
// in neuron order, with back-pressure, a layer-done pulse and sticky overrun detection.
module layer_out_sequencer #(
  parameter int unsigned NN        = 30,
  parameter int unsigned dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  input  logic                    x_ready,
  input  logic                    err_clr,
  output logic                    x_valid,
  output logic [dataWidth-1:0]    x_out,
  output logic [$clog2(NN)-1:0]   x_idx,
  output logic                    x_last,
  output logic                    layer_done,
  output logic                    overrun
);

  localparam int unsigned IW = $clog2(NN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    STREAM  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NN-1:0]          mask_q, mask_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;
  logic                   ovr_set_c;
  logic [NN-1:0]          cap_c;
  logic                   last_c;
  logic [dataWidth-1:0]   data_q [NN];

  assign last_c = (idx_q == LAST_IDX);

  // Control state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= COLLECT;
      mask_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state, capture enables and overrun detection
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    cap_c     = '0;
    ovr_set_c = 1'b0;
    case (state_q)
      COLLECT: begin
        cap_c     = i_valid & ~mask_q;
        mask_d    = mask_q | i_valid;
        ovr_set_c = |(i_valid & mask_q);
        if (&(mask_q | i_valid)) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        // No double buffering: anything arriving now is lost
        ovr_set_c = |i_valid;
        if (x_ready) begin
          if (last_c) begin
            state_d = COLLECT;
            mask_d  = '0;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
    // A new overrun event takes priority over a coincident clear
    if (ovr_set_c) begin
      ovr_d = 1'b1;
    end else if (err_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Per-neuron result buffer, written only on first capture of each lane
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NN; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NN; i++) begin
        if (cap_c[i]) begin
          data_q[i] <= i_data[i*dataWidth +: dataWidth];
        end
      end
    end
  end

  assign x_valid    = (state_q == STREAM);
  assign x_idx      = idx_q;
  assign x_out      = x_valid ? data_q[idx_q] : '0;
  assign x_last     = x_valid && last_c;
  assign layer_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_layer_out_sequencer.sv
// Directed self-checking bench for layer_out_sequencer: vector table plus
// hand-written back-pressure, overrun, back-to-back and async-reset sequences.
module tb_layer_out_sequencer;

  localparam int unsigned NN = 30;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = $clog2(NN);

  logic             clk = 1'b0;
  logic             rstn;
  logic [NN-1:0]    i_valid;
  logic [NN*DW-1:0] i_data;
  logic             x_ready;
  logic             err_clr;
  logic             x_valid;
  logic [DW-1:0]    x_out;
  logic [IW-1:0]    x_idx;
  logic             x_last;
  logic             layer_done;
  logic             overrun;

  int n_tests = 0;
  int n_fail  = 0;

  layer_out_sequencer #(.NN(NN), .dataWidth(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .x_ready    (x_ready),
    .err_clr    (err_clr),
    .x_valid    (x_valid),
    .x_out      (x_out),
    .x_idx      (x_idx),
    .x_last     (x_last),
    .layer_done (layer_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string         name;
    logic [NN-1:0] vld;
    logic [DW-1:0] base;
    logic          rdy;
    logic          clr;
    logic [24:0]   expv;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [24:0] pk(input logic v, input logic [IW-1:0] i,
                                     input logic [DW-1:0] o, input logic l,
                                     input logic d, input logic ov);
    return {v, i, o, l, d, ov};
  endfunction

  function automatic logic [24:0] obs();
    return pk(x_valid, x_idx, x_out, x_last, layer_done, overrun);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic set_in(input logic [NN-1:0] v, input logic [DW-1:0] base,
                        input logic r, input logic c);
    i_valid = v;
    for (int i = 0; i < NN; i++) i_data[i*DW +: DW] = base + DW'(i);
    x_ready = r;
    err_clr = c;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic add(input string n, input logic [NN-1:0] v, input logic [DW-1:0] b,
                     input logic r, input logic c, input logic [24:0] e);
    vec_t t;
    t.name = n; t.vld = v; t.base = b; t.rdy = r; t.clr = c; t.expv = e;
    tbl.push_back(t);
  endtask

  // Checks 30 beats of base+k with x_ready high, ending in the layer_done cycle
  task automatic stream_beats(input logic [DW-1:0] base, input string nm);
    for (int k = 0; k < NN; k++) begin
      chk(nm, 32'(obs()), 32'(pk(1'b1, IW'(k), base + DW'(k), k == NN-1, 1'b0, 1'b0)));
      set_in('0, '0, 1'b1, 1'b0);
      tick();
    end
    chk({nm, "_done"}, 32'(obs()), 32'(pk(1'b0, '0, '0, 1'b0, 1'b1, 1'b0)));
  endtask

  logic [NN-1:0] all_v;
  logic [NN-1:0] v;
  logic [3:0]    pat;
  logic          c;
  logic          ovr_m;
  int            e_idx, xfers, cyc, dones;
  logic [DW-1:0] e_out;

  initial begin
    all_v = '1;
    rstn  = 1'b0;
    set_in('0, '0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("reset_state", 32'(obs()), 32'(pk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
    rstn = 1'b1;

    // Simultaneous capture
    add("s1_load", all_v, 16'h0100, 1'b1, 1'b0, pk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < NN; k++)
      add("s1_beat", '0, '0, 1'b1, 1'b0,
          pk(1'b1, IW'(k), 16'h0100 + DW'(k), k == NN-1, 1'b0, 1'b0));
    add("s1_done", '0, '0, 1'b1, 1'b0, pk(1'b0, '0, '0, 1'b0, 1'b1, 1'b0));
    add("s1_idle", '0, '0, 1'b1, 1'b0, pk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0));
    // Scattered arrival in reverse neuron order
    for (int j = 0; j < NN; j++) begin
      v = '0;
      v[NN-1-j] = 1'b1;
      add("s2_arrive", v, 16'h0200, 1'b1, 1'b0, pk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0));
    end
    for (int k = 0; k < NN; k++)
      add("s2_beat", '0, '0, 1'b1, 1'b0,
          pk(1'b1, IW'(k), 16'h0200 + DW'(k), k == NN-1, 1'b0, 1'b0));
    add("s2_done", '0, '0, 1'b1, 1'b0, pk(1'b0, '0, '0, 1'b0, 1'b1, 1'b0));
    add("s2_idle", '0, '0, 1'b1, 1'b0, pk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0));

    foreach (tbl[r]) begin
      chk(tbl[r].name, 32'(obs()), 32'(tbl[r].expv));
      set_in(tbl[r].vld, tbl[r].base, tbl[r].rdy, tbl[r].clr);
      tick();
    end

    // Back-pressure with ready pattern 1,0,0,1
    pat = 4'b1001;
    set_in(all_v, 16'h0300, 1'b0, 1'b0);
    tick();
    set_in('0, '0, 1'b0, 1'b0);
    e_idx = 0; xfers = 0; cyc = 0;
    while (xfers < NN && cyc < 200) begin
      chk("bp_beat", 32'(obs()),
          32'(pk(1'b1, IW'(e_idx), 16'h0300 + DW'(e_idx), e_idx == NN-1, 1'b0, 1'b0)));
      x_ready = pat[cyc % 4];
      tick();
      if (pat[cyc % 4]) begin
        xfers++;
        e_idx++;
      end
      cyc++;
    end
    chk("bp_xfers", 32'(xfers), 32'(NN));
    chk("bp_done_first", 32'({x_valid, layer_done}), 32'(2'b01));
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      dones += int'(layer_done);
      tick();
    end
    chk("bp_done_count", 32'(dones), 32'd1);

    // Overrun (a): duplicate capture on neuron 3
    set_in(16'h0008, 16'hA000, 1'b1, 1'b0);
    tick();
    chk("ovr_a_first", 32'({x_valid, overrun}), 32'(2'b00));
    set_in(16'h0008, 16'hB000, 1'b1, 1'b0);
    tick();
    chk("ovr_a_set", 32'({x_valid, overrun}), 32'(2'b01));
    v = all_v;
    v[3] = 1'b0;
    set_in(v, 16'hC000, 1'b1, 1'b0);
    tick();
    ovr_m = 1'b1;
    // Overrun (b): arrivals during stream, clear, and clear-vs-set priority
    for (int k = 0; k < NN; k++) begin
      e_out = (k == 3) ? 16'hA003 : 16'hC000 + DW'(k);
      chk("ovr_beat", 32'(obs()), 32'(pk(1'b1, IW'(k), e_out, k == NN-1, 1'b0, ovr_m)));
      v = '0;
      c = 1'b0;
      case (k)
        0: c = 1'b1;
        2: v[5] = 1'b1;
        4: begin c = 1'b1; v[7] = 1'b1; end
        6: c = 1'b1;
        default: ;
      endcase
      set_in(v, 16'hD000, 1'b1, c);
      tick();
      if (v != '0) ovr_m = 1'b1;
      else if (c) ovr_m = 1'b0;
      chk("ovr_flag", 32'(overrun), 32'(ovr_m));
    end
    chk("ovr_done", 32'(obs()), 32'(pk(1'b0, '0, '0, 1'b0, 1'b1, 1'b0)));
    set_in('0, '0, 1'b1, 1'b0);
    tick();

    // Back-to-back layers: second set lands in the layer_done cycle
    set_in(all_v, 16'h4000, 1'b1, 1'b0);
    tick();
    stream_beats(16'h4000, "b2b_first");
    set_in(all_v, 16'h5000, 1'b1, 1'b0);
    tick();
    chk("b2b_second_start", 32'(obs()), 32'(pk(1'b1, '0, 16'h5000, 1'b0, 1'b0, 1'b0)));
    stream_beats(16'h5000, "b2b_second");
    set_in('0, '0, 1'b1, 1'b0);
    tick();

    // Asynchronous reset between edges at beat 12
    set_in(all_v, 16'h6000, 1'b1, 1'b0);
    tick();
    set_in('0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++) tick();
    chk("rst_pre", 32'(obs()), 32'(pk(1'b1, IW'(12), 16'h600C, 1'b0, 1'b0, 1'b0)));
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_async", 32'(obs()), 32'(pk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
    tick();
    chk("rst_held", 32'(obs()), 32'(pk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0)));
    rstn = 1'b1;
    set_in(all_v, 16'h7000, 1'b1, 1'b0);
    tick();
    set_in('0, '0, 1'b1, 1'b0);
    stream_beats(16'h7000, "rst_recover");
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_out_sequencer.md
# layer_out_sequencer

Collects the `NN` parallel neuron results of one fully-connected layer and streams them in neuron order as a serial sample stream. The stream feeds the next layer's shared `x_valid`/`x_in` input or the output capture logic. The block sits between a layer instance (which produces `o_valid[NN-1:0]` and `x_out[NN*dataWidth-1:0]`) and its consumer. It provides per-neuron result buffering, downstream flow control, a layer-done pulse and overrun detection.

## Interface
**Parameters**
- `NN`, 30: number of neurons in the producing layer; must be ≥ 2.
- `dataWidth`, 16: width of one neuron result.

**Ports**
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `i_valid`, input, NN: per-neuron result-valid pulse; bit i qualifies `i_data[i*dataWidth+:dataWidth]`.
- `i_data`, input, NN*dataWidth: parallel neuron results.
- `x_ready`, input, 1: consumer accepts the current beat when high.
- `err_clr`, input, 1: synchronous clear of `overrun`.
- `x_valid`, output, 1: serial beat valid.
- `x_out`, output, dataWidth: serial beat data, neuron index `x_idx`.
- `x_idx`, output, $clog2(NN): index of the neuron currently presented.
- `x_last`, output, 1: high with the beat of neuron NN-1.
- `layer_done`, output, 1: one-cycle pulse after the last beat is accepted.
- `overrun`, output, 1: sticky error flag.

## Operation
**States**
- `COLLECT`
  - Register bank `buf[0..NN-1]` and capture mask `mask[NN-1:0]` are active.
  - For each i with `i_valid[i]`=1 and `mask[i]`=0: `buf[i]` ← `i_data[i]` and `mask[i]` ← 1.
  - When `i_valid[i]`=1 and `mask[i]` is already 1: data is discarded, `buf[i]` is unchanged, and `overrun` ← 1.
  - When `mask | i_valid` becomes all-ones in a cycle, the next state is `STREAM` and `idx` ← 0.
  - Results may arrive in any order and spread over any number of cycles.
- `STREAM`
  - `x_valid`=1, `x_out`=`buf[idx]`, `x_idx`=`idx`, `x_last`=(`idx`==NN-1).
  - A beat transfers when `x_valid` && `x_ready`; `idx` then increments.
  - When the NN-1 beat transfers: the next state is `COLLECT`, `mask` ← 0, and `layer_done` pulses in the following cycle.
  - Any `i_valid` bit high while in `STREAM`: data is discarded and `overrun` ← 1. There is no double buffering.
- **Overrun flag**: `overrun` is sticky. `err_clr` clears it. If `err_clr` and a new overrun event occur in the same cycle, the set wins.
- **Index width**: `idx` is $clog2(NN) bits. It never wraps past NN-1, because the last beat forces the return to `COLLECT`.
- `buf` is not cleared between layers. Stale contents are never streamed, because `mask` gates entry to `STREAM`.

## Timing
- **Reset** (`rstn`=0, asynchronous): state=`COLLECT`, `mask`=0, `idx`=0, `x_valid`=0, `x_out`=0, `x_idx`=0, `x_last`=0, `layer_done`=0, `overrun`=0. `buf` is reset to 0.
- **Reset mid-stream**: the layer in progress is abandoned. Outputs take their reset values immediately, without waiting for a clock edge.
- **Latency from final result to first beat**: the final `i_valid` is sampled at edge N, and `x_valid` is high after edge N. That is one cycle.
- **Throughput**: with `x_ready` held high, NN beats occur on NN consecutive cycles.
- **Return to collection**: `COLLECT` resumes in the cycle after the last transfer. A result arriving in that cycle is captured normally.
- **Back-pressure**: while `x_ready`=0, `x_valid`, `x_out`, `x_idx` and `x_last` hold stable, with no limit on duration.
- `x_valid` never drops in `STREAM` until the last beat transfers.
- `layer_done` is registered and goes high in the cycle after the last transfer, which is the first `COLLECT` cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `i_valid` or `x_ready` to any output.

## Test plan
- **Simultaneous capture**
  - Stimulus: NN=30, all `i_valid`=1 for one cycle with `i_data[i]`=16'h0100+i, and `x_ready`=1.
  - Required: `x_valid` rises 1 cycle later; 30 consecutive beats 16'h0100..16'h011D; `x_last` on idx 29; `layer_done` pulse the next cycle; `overrun`=0.
- **Scattered arrival**
  - Stimulus: results arrive one neuron per cycle in reverse order 29..0.
  - Required: no `x_valid` before neuron 0 arrives; stream order is still 0..29 with the correct data.
- **Back-pressure**
  - Stimulus: toggle `x_ready` 1,0,0,1 repeating during the stream.
  - Required: data is stable while stalled; exactly 30 transfers; `layer_done` once.
- **Overrun**
  - Stimulus (a): `i_valid[3]` twice in `COLLECT` with data A then B.
  - Stimulus (b): any `i_valid` during `STREAM`.
  - Required: for (a), beat 3 = A and `overrun`=1. For (b), `overrun`=1 and the stream is unaffected. `err_clr` then clears `overrun`. `err_clr` coincident with a new overrun event leaves `overrun`=1.
- **Back-to-back layers**
  - Stimulus: the second full result set arrives in the cycle after `x_last` transfers.
  - Required: it is captured, and the second stream starts 1 cycle after `layer_done` rises.
- **Asynchronous reset mid-stream**
  - Stimulus: assert `rstn`=0 at beat 12 between clock edges.
  - Required: outputs reset immediately; after release, a full new layer streams correctly starting at idx 0.
